// File: rtl/point_add_if.sv
// point_add_if -- operand/result bundle for the point_add group-addition unit.
//
// Signals
//   P          2W  point P = {Px, Py}, driven by the requester
//   Q          2W  point Q = {Qx, Qy}, driven by the requester
//   R          2W  result R = {Rx, Ry}, driven by point_add
//   Done        1  high while R holds a finished result
//   dbg_state   4  current controller state, for checkers and debug
//
// Modports
//   master  requester side (drives P, Q)
//   slave   point_add side (drives R, Done, dbg_state)
interface point_add_if #(
    parameter int W = 256
);
    logic [2*W-1:0] P;
    logic [2*W-1:0] Q;
    logic [2*W-1:0] R;
    logic           Done;
    logic [3:0]     dbg_state;

    modport master (output P, Q, input R, Done, dbg_state);
    modport slave  (input P, Q, output R, Done, dbg_state);
endinterface

// File: rtl/point_add.sv
// point_add -- affine elliptic-curve point adder over GF(PRIME): R = P + Q, P != +/-Q.
//
// Datapath: one bit-serial MSB-first modular multiplier (W+1 cycles per product),
// one binary extended-Euclid inverter (one iteration per cycle) and modular
// subtractors with a single conditional +PRIME correction.
//
// Ports
//   clk     in   rising-edge clock
//   Reset   in   asynchronous active-low reset; aborts any computation
//   bus     slave modport of point_add_if (P, Q in; R, Done, dbg_state out)
//
// Handshake: there is no valid/ready pair. Leaving reset starts one computation
// on the P, Q present at the first rising edge; Done rises together with R and
// both then hold. R only changes on the edge that also sets Done (or on reset).
//
// Build option
//   POINT_ADD_RESTART_EN  when defined, a finished unit watches P, Q and reruns
//                         the computation whenever they differ from the latched
//                         operands (Done drops, old R held until the new result).
//                         When undefined the finished state is terminal until reset.
module point_add #(
    parameter int           W     = 256,
    parameter logic [W-1:0] PRIME = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
    input  logic      clk,
    input  logic      Reset,
    point_add_if.slave bus
);

    localparam int           CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W);
    localparam logic [W-1:0]  ONE      = W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_SUB, S_INV, S_MUL_L, S_SQR, S_SUBX, S_SUBY, S_MUL_Y, S_FIN, S_DONE
    } state_t;

    state_t state, state_n;

    // latched operands
    logic [W-1:0] px, py, qx, qy;
    // intermediates
    logic [W-1:0] dy, lam, t, rx;
    // inverter: invariants x1*dx == u, x2*dx == v (mod PRIME)
    logic [W-1:0] u, v, x1, x2;
    // multiplier
    logic [W-1:0]  ma, mb, acc;
    logic [CW-1:0] cnt;
    logic          phase;
    // outputs
    logic [2*W-1:0] r_q;
    logic           done_q;

    // (a - b) mod PRIME for a, b < PRIME: one borrow-driven correction
    function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + {1'b0, PRIME};
        return d[W-1:0];
    endfunction

    // x/2 mod PRIME: odd values get PRIME added first (PRIME is odd)
    function automatic logic [W-1:0] f_half(input logic [W-1:0] x);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, PRIME}) : {1'b0, x};
        return s[W:1];
    endfunction

    // one interleaved step: 2*acc + bit*a < 3*PRIME, so two subtractions suffice
    function automatic logic [W-1:0] f_mul_step(input logic [W-1:0] acc_in,
                                                 input logic [W-1:0] a,
                                                 input logic         bit_in);
        logic [W+1:0] s;
        logic [W+1:0] p2;
        p2 = {2'b00, PRIME};
        s  = {1'b0, acc_in, 1'b0} + (bit_in ? {2'b00, a} : '0);
        if (s >= p2) s = s - p2;
        if (s >= p2) s = s - p2;
        return s[W-1:0];
    endfunction

    logic         mul_last;
    logic         inv_end;
    logic         load_ops;
    logic [W-1:0] mul_a_src, mul_b_src, mul_next;

    assign mul_last = (cnt == CNT_LAST);
    assign inv_end  = (u == ONE) || (v == ONE);
    assign mul_next = f_mul_step(acc, ma, mb[W-1]);

`ifdef POINT_ADD_RESTART_EN
    logic changed;
    assign changed  = ({bus.P, bus.Q} != {px, py, qx, qy});
    assign load_ops = (state == S_IDLE) || ((state == S_DONE) && changed);
`else
    assign load_ops = (state == S_IDLE);
`endif

    always_comb begin
        mul_a_src = '0;
        mul_b_src = '0;
        case (state)
            S_MUL_L: begin mul_a_src = dy;  mul_b_src = x1;  end
            S_SQR:   begin mul_a_src = acc; mul_b_src = acc; end
            S_MUL_Y: begin mul_a_src = lam; mul_b_src = t;   end
            default: ;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // next state
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = S_SUB;
            // equal x-coordinates: dx has no inverse, skip straight to a zero result
            S_SUB:   state_n = (px == qx) ? S_FIN : S_INV;
            S_INV:   if (inv_end)  state_n = S_MUL_L;
            S_MUL_L: if (mul_last) state_n = S_SQR;
            S_SQR:   if (mul_last) state_n = S_SUBX;
            S_SUBX:  if (phase)    state_n = S_SUBY;
            S_SUBY:  state_n = S_MUL_Y;
            S_MUL_Y: if (mul_last) state_n = S_FIN;
            S_FIN:   state_n = S_DONE;
            S_DONE: begin
`ifdef POINT_ADD_RESTART_EN
                if (changed) state_n = S_SUB;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    // datapath
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            px <= '0; py <= '0; qx <= '0; qy <= '0;
            dy <= '0; lam <= '0; t <= '0; rx <= '0;
            u <= '0; v <= '0; x1 <= '0; x2 <= '0;
            ma <= '0; mb <= '0; acc <= '0; cnt <= '0;
            phase  <= 1'b0;
            r_q    <= '0;
            done_q <= 1'b0;
        end else begin
            if (load_ops) begin
                px <= bus.P[2*W-1:W];
                py <= bus.P[W-1:0];
                qx <= bus.Q[2*W-1:W];
                qy <= bus.Q[W-1:0];
            end
`ifdef POINT_ADD_RESTART_EN
            if ((state == S_DONE) && changed) done_q <= 1'b0;
`endif
            case (state)
                S_SUB: begin
                    u  <= f_sub(qx, px);
                    v  <= PRIME;
                    x1 <= ONE;
                    x2 <= '0;
                    dy <= f_sub(qy, py);
                end
                S_INV: begin
                    // on exit x1 carries dx^-1 into the first multiplication
                    if (inv_end) begin
                        if (u != ONE) x1 <= x2;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= f_half(x1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= f_half(x2);
                    end else if (u >= v) begin
                        // both odd: difference is even, halve in the same cycle
                        u  <= (u - v) >> 1;
                        x1 <= f_half(f_sub(x1, x2));
                    end else begin
                        v  <= (v - u) >> 1;
                        x2 <= f_half(f_sub(x2, x1));
                    end
                end
                S_MUL_L, S_SQR, S_MUL_Y: begin
                    if (cnt == '0) begin
                        ma  <= mul_a_src;
                        mb  <= mul_b_src;
                        acc <= '0;
                        cnt <= CW'(1);
                        // acc still holds L from MUL_L here
                        if (state == S_SQR) lam <= acc;
                    end else begin
                        acc <= mul_next;
                        mb  <= mb << 1;
                        cnt <= mul_last ? '0 : cnt + CW'(1);
                    end
                end
                S_SUBX: begin
                    if (!phase) t  <= f_sub(acc, px);   // L^2 - Px
                    else        rx <= f_sub(t, qx);     // - Qx
                    phase <= ~phase;
                end
                S_SUBY: t <= f_sub(px, rx);
                S_FIN: begin
                    r_q    <= (px == qx) ? '0 : {rx, f_sub(acc, py)};
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.R         = r_q;
    assign bus.Done      = done_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_point_add.sv
module tb_point_add;

    localparam int           W     = 256;
    localparam logic [W-1:0] PR    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int           LIMIT = 1400;
    localparam int           N_RND = 40;

    localparam logic [W-1:0] GX  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [W-1:0] GY  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [W-1:0] G2X = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
    localparam logic [W-1:0] G2Y = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
    localparam logic [W-1:0] G3X = 256'hF9308A01_9258C310_49344F85_F89D5229_B531C845_836F99B0_8601F113_BCE036F9;
    localparam logic [W-1:0] G3Y = 256'h388F7B0F_632DE814_0FE337E6_2A37F356_6500A999_34C2231B_6CB9FD75_84B8E672;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    point_add_if #(.W(W)) bus ();
    point_add #(.W(W), .PRIME(PR)) dut (.clk(clk), .Reset(rst_n), .bus(bus));

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q[$];

    // software field model
    function automatic logic [W-1:0] m_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] pr;
        pr = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        pr = pr % {{W{1'b0}}, PR};
        return pr[W-1:0];
    endfunction

    function automatic logic [W-1:0] m_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (a + (PR - b));
    endfunction

    // Fermat inverse a^(p-2)
    function automatic logic [W-1:0] m_inv(input logic [W-1:0] a);
        logic [W-1:0] e;
        logic [W-1:0] r;
        e = PR - W'(2);
        r = W'(1);
        for (int i = W - 1; i >= 0; i--) begin
            r = m_mul(r, r);
            if (e[i]) r = m_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [2*W-1:0] m_padd(input logic [W-1:0] ax, input logic [W-1:0] ay,
                                              input logic [W-1:0] bx, input logic [W-1:0] by);
        logic [W-1:0] l, rx, ry;
        if (ax == bx) return '0;
        l  = m_mul(m_sub(by, ay), m_inv(m_sub(bx, ax)));
        rx = m_sub(m_sub(m_mul(l, l), ax), bx);
        ry = m_sub(m_mul(l, m_sub(ax, rx)), ay);
        return {rx, ry};
    endfunction

    function automatic logic [W-1:0] rnd_fe();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        if (r >= PR) r = r - PR;
        return r;
    endfunction

    // driver tasks
    task automatic apply(input logic [2*W-1:0] p, input logic [2*W-1:0] q);
        @(negedge clk);
        bus.P = p;
        bus.Q = q;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(output int cyc, output bit timed_out);
        cyc = 0;
        while (!bus.Done && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        timed_out = !bus.Done;
    endtask

    // tests
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.R !== '0) begin bad++; $display("FAIL reset_r got=%h exp=0", bus.R); end
        total++;
        if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.Done); end
    endtask

    task automatic test_small();
        logic [2*W-1:0] e, got;
        int cyc;
        bit to;
        // L = 0
        exp_q.push_back({PR - W'(14), PR - W'(1)});
        apply({W'(6), W'(1)}, {W'(8), W'(1)});
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to) begin bad++; $display("FAIL small_l0 timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL small_l0 got=%h exp=%h", got, e); end
        // L = 3
        exp_q.push_back({W'(6), PR - W'(17)});
        apply({W'(1), W'(2)}, {W'(2), W'(5)});
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to) begin bad++; $display("FAIL small_l3 timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL small_l3 got=%h exp=%h", got, e); end
    endtask

    task automatic test_generator();
        logic [2*W-1:0] e, got;
        int cyc;
        bit to;
        exp_q.push_back({G3X, G3Y});
        apply({GX, GY}, {G2X, G2Y});
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to) begin bad++; $display("FAIL g_3g timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL g_3g got=%h exp=%h", got, e); end
        total++;
        if (cyc > 1300) begin bad++; $display("FAIL g_latency got=%0d exp<=1300", cyc); end
    endtask

    task automatic test_equal_x();
        logic [2*W-1:0] e, got;
        int cyc;
        bit to;
        exp_q.push_back('0);
        apply({W'(5), W'(7)}, {W'(5), W'(9)});
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to || bus.Done !== 1'b1) begin bad++; $display("FAIL eqx_done timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL eqx_r got=%h exp=%h", got, e); end
        total++;
        if (cyc >= 20) begin bad++; $display("FAIL eqx_latency got=%0d exp<20", cyc); end
    endtask

    task automatic test_random();
        logic [W-1:0] ax, ay, bx, by;
        logic [2*W-1:0] e, got;
        int cyc;
        bit to;
        for (int n = 0; n < N_RND; n++) begin
            ax = rnd_fe(); ay = rnd_fe(); bx = rnd_fe(); by = rnd_fe();
            exp_q.push_back(m_padd(ax, ay, bx, by));
            apply({ax, ay}, {bx, by});
            wait_done(cyc, to);
            e = exp_q.pop_front();
            got = bus.R;
            total++;
            if (to) begin bad++; $display("FAIL rnd_%0d timeout after %0d cycles", n, cyc); end
            else if (got !== e || cyc > 1300) begin
                bad++;
                $display("FAIL rnd_%0d got=%h exp=%h cyc=%0d", n, got, e, cyc);
            end
        end
    endtask

    task automatic test_abort();
        logic [2*W-1:0] e, got;
        int cyc;
        bit to;
        bit early;
        apply({GX, GY}, {G2X, G2Y});
        early = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.Done !== 1'b0) early = 1'b1;
        end
        total++;
        if (early) begin bad++; $display("FAIL abort_early got=1 exp=0"); end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.R !== '0 || bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL abort_clear got=%h/%b exp=0/0", bus.R, bus.Done);
        end
        @(negedge clk);
        exp_q.push_back({G3X, G3Y});
        rst_n = 1'b1;
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to) begin bad++; $display("FAIL abort_rerun timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL abort_rerun got=%h exp=%h", got, e); end
    endtask

    task automatic test_restart();
        logic [2*W-1:0] first, e, got;
        int cyc;
        bit to;
        first = {PR - W'(14), PR - W'(1)};
        exp_q.push_back(first);
        apply({W'(6), W'(1)}, {W'(8), W'(1)});
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to) begin bad++; $display("FAIL rs_first timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL rs_first got=%h exp=%h", got, e); end
        @(negedge clk);
        bus.P = {W'(1), W'(2)};
        bus.Q = {W'(2), W'(5)};
`ifdef POINT_ADD_RESTART_EN
        exp_q.push_back({W'(6), PR - W'(17)});
        @(posedge clk);
        #1;
        total++;
        if (bus.Done !== 1'b0 || bus.R !== first) begin
            bad++;
            $display("FAIL rs_drop got=%b/%h exp=0/%h", bus.Done, bus.R, first);
        end
        wait_done(cyc, to);
        e = exp_q.pop_front();
        got = bus.R;
        total++;
        if (to) begin bad++; $display("FAIL rs_rerun timeout after %0d cycles", cyc); end
        else if (got !== e) begin bad++; $display("FAIL rs_rerun got=%h exp=%h", got, e); end
`else
        repeat (50) @(negedge clk);
        total++;
        if (bus.Done !== 1'b1 || bus.R !== first) begin
            bad++;
            $display("FAIL rs_hold got=%b/%h exp=1/%h", bus.Done, bus.R, first);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        bus.P = '0;
        bus.Q = '0;
        test_reset();
        test_small();
        test_generator();
        test_equal_x();
        test_abort();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
